// File: rtl/z2_cycle_gen.sv
// z2_cycle_gen -- Zorro II bus-cycle generator (bus master side).
//
// Purpose: commands enter through a small show-ahead FIFO and each one is
// played out as a complete Zorro II cycle. The phases run in order:
// address/READ setup, /AS, /UDS+/LDS, the DOE data phase, and release.
// Phase lengths are counted in z_sample_clk cycles. When the cycle
// completes, a one-cycle response is issued.
//
// Optional feature macro: Z2CG_TIMEOUT_EN. When it is defined, a slave that
// holds zXRDY low for TIMEOUT cycles after the minimum strobe time has
// elapsed aborts the cycle, and the response reports rsp_err=1.
//
// Ports:
//   z_sample_clk, reset_n     clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_read/addr/wdata/be    command payload (be[1]=UDS, be[0]=LDS)
//   rsp_valid                 one-cycle completion pulse, no backpressure
//   rsp_read/rdata/err        response payload
//   znAS/znUDS/znLDS          active-low bus strobes
//   zREAD, zA, zDOE           direction, address, data output enable phase
//   zD_out/zD_oe/zD_in        split tristate data bus
//   zXRDY                     slave ready (low inserts wait states)
//   o_dbg_state               current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is simply "FIFO not full". The
// response side has no ready: rsp_valid is high for exactly one cycle
// per completed bus cycle.
module z2_cycle_gen #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int T_ADDR     = 13,
  parameter int T_AS2DS    = 14,
  parameter int T_DS       = 20,
  parameter int T_DOE      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic              z_sample_clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [1:0]        cmd_be,
  output logic              rsp_valid,
  output logic              rsp_read,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              znAS,
  output logic              znUDS,
  output logic              znLDS,
  output logic              zREAD,
  output logic [ADDR_W-1:0] zA,
  output logic              zDOE,
  output logic [DATA_W-1:0] zD_out,
  output logic              zD_oe,
  input  logic [DATA_W-1:0] zD_in,
  input  logic              zXRDY,
  output logic [2:0]        o_dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + ADDR_W + DATA_W + 2;
  localparam int T_M1  = (T_ADDR > T_AS2DS) ? T_ADDR : T_AS2DS;
  localparam int T_M2  = (T_DS > T_DOE) ? T_DS : T_DOE;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AS, S_DS, S_HOLD, S_END
  } state_t;

  state_t r_state, w_next;

  // ---------------- command FIFO (show-ahead) ----------------
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_full, w_empty, w_push, w_pop;
  logic [ENT_W-1:0] w_head;

  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge z_sample_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_read, cmd_addr, cmd_wdata, cmd_be};
  end

  always_ff @(posedge z_sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- latched command ----------------
  logic              r_read;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_be;

  always_ff @(posedge z_sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 2'b00;
    end else if (w_pop) begin
      r_read  <= w_head[ENT_W-1];
      r_addr  <= w_head[ENT_W-2 -: ADDR_W];
      r_wdata <= w_head[2 +: DATA_W];
      r_be    <= w_head[1:0];
    end
  end

  assign zA     = r_addr;
  assign zD_out = r_wdata;

  // ---------------- phase counter / timeout ----------------
  logic [CNT_W-1:0] r_cnt, w_cnt_val;
  logic             w_cnt_load;
  logic             w_err;

`ifdef Z2CG_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_err;
  logic              w_timeout_hit;

  // Counts consecutive not-ready cycles once the minimum strobe time is over;
  // any cycle with zXRDY=1 at that point leaves DS, so no explicit clear is needed.
  always_ff @(posedge z_sample_clk or negedge reset_n) begin
    if (!reset_n)                                  r_wcnt <= '0;
    else if (r_state != S_DS)                      r_wcnt <= '0;
    else if (r_cnt == '0 && !zXRDY && !w_timeout_hit) r_wcnt <= r_wcnt + 1'b1;
  end

  always_ff @(posedge z_sample_clk or negedge reset_n) begin
    if (!reset_n)           r_err <= 1'b0;
    else if (w_pop)         r_err <= 1'b0;
    else if (w_timeout_hit) r_err <= 1'b1;
  end

  assign w_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_err            = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
`ifdef Z2CG_TIMEOUT_EN
    w_timeout_hit = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_next = S_ADDR; w_cnt_load = 1'b1; w_cnt_val = CNT_W'(T_ADDR - 1);
      end
      S_ADDR: if (r_cnt == '0) begin
        w_next = S_AS; w_cnt_load = 1'b1; w_cnt_val = CNT_W'(T_AS2DS - 1);
      end
      S_AS: if (r_cnt == '0) begin
        w_next = S_DS; w_cnt_load = 1'b1; w_cnt_val = CNT_W'(T_DS - 1);
      end
      S_DS: if (r_cnt == '0) begin
        if (zXRDY) begin
          w_next = S_HOLD; w_cnt_load = 1'b1; w_cnt_val = CNT_W'(T_DOE - 1);
        end
`ifdef Z2CG_TIMEOUT_EN
        else if (r_wcnt == WCNT_W'(TIMEOUT)) begin
          w_next = S_HOLD; w_cnt_load = 1'b1; w_cnt_val = CNT_W'(T_DOE - 1);
          w_timeout_hit = 1'b1;
        end
`endif
      end
      S_HOLD: if (r_cnt == '0) w_next = S_END;
      S_END:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge z_sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_load)        r_cnt <= w_cnt_val;
      else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_dbg_state = r_state;

  // ---------------- registered bus outputs ----------------
  // Outputs are decoded from the next state and registered, so the strobes
  // are glitch-free and still change on the same edge as the state.
  logic w_as_phase;
  assign w_as_phase = (w_next == S_AS) || (w_next == S_DS) || (w_next == S_HOLD);

  always_ff @(posedge z_sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      znAS  <= 1'b1;
      znUDS <= 1'b1;
      znLDS <= 1'b1;
      zREAD <= 1'b1;
      zDOE  <= 1'b0;
      zD_oe <= 1'b0;
    end else begin
      znAS  <= !w_as_phase;
      znUDS <= !((w_next == S_DS) && r_be[1]);
      znLDS <= !((w_next == S_DS) && r_be[0]);
      // The pop edge must already show the new command's direction.
      zREAD <= (w_next == S_IDLE) ? 1'b1 : (w_pop ? w_head[ENT_W-1] : r_read);
      zDOE  <= (w_next == S_HOLD);
      zD_oe <= w_as_phase && !r_read;
    end
  end

  // ---------------- response ----------------
  always_ff @(posedge z_sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_read  <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if ((r_state == S_HOLD) && (w_next == S_END)) begin
      rsp_valid <= 1'b1;
      rsp_read  <= r_read;
      rsp_rdata <= (r_read && !w_err) ? zD_in : '0;
      rsp_err   <= w_err;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z2_cycle_gen.sv
module tb_z2_cycle_gen;
  localparam int ADDR_W = 24, DATA_W = 16, FIFO_DEPTH = 4;
  localparam int T_ADDR = 13, T_AS2DS = 14, T_DS = 20, T_DOE = 8, TIMEOUT = 64;
  // Edges from one pop to the next when commands are queued back to back.
  localparam int CYC = 1 + T_ADDR + T_AS2DS + T_DS + T_DOE + 1;

  logic              z_sample_clk, reset_n;
  logic              cmd_valid, cmd_ready, cmd_read;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [1:0]        cmd_be;
  logic              rsp_valid, rsp_read, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              znAS, znUDS, znLDS, zREAD, zDOE, zD_oe, zXRDY;
  logic [ADDR_W-1:0] zA;
  logic [DATA_W-1:0] zD_out, zD_in;
  logic [2:0]        dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W:0]   exp_q[$];

  z2_cycle_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .T_ADDR(T_ADDR),
    .T_AS2DS(T_AS2DS), .T_DS(T_DS), .T_DOE(T_DOE), .TIMEOUT(TIMEOUT)
  ) dut (
    .z_sample_clk(z_sample_clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_read(rsp_read), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .znAS(znAS), .znUDS(znUDS), .znLDS(znLDS), .zREAD(zREAD), .zA(zA), .zDOE(zDOE),
    .zD_out(zD_out), .zD_oe(zD_oe), .zD_in(zD_in), .zXRDY(zXRDY),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial z_sample_clk = 1'b0;
  always #5 z_sample_clk = ~z_sample_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] ctl_obs();
    return {znAS, znUDS, znLDS, zREAD, zDOE, zD_oe, rsp_valid, cmd_ready};
  endfunction

  task automatic check_reset_vals(input string tag);
    chk($sformatf("%s_ctl", tag), ctl_obs(), 8'b1111_0001);
    chk($sformatf("%s_zA", tag), zA, 0);
    chk($sformatf("%s_zD_out", tag), zD_out, 0);
    chk($sformatf("%s_rsp", tag), {rsp_read, rsp_err, rsp_rdata}, 0);
  endtask

  // ---------------- single-cycle driver + timeline model ----------------
  // Starts and ends at a negedge with the generator idle and the FIFO empty.
  // The expected waveform is derived from phase boundaries relative to the
  // push edge (edge 0).
  task automatic run_cycle(input logic rd, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [1:0] be,
                           input logic [DATA_W-1:0] rdata, input int waits,
                           input bit stuck, input string tag);
    int t_as, t_ds, t_ds_end, t_hold, t_end, w;
    logic [DATA_W-1:0] exp_rdata;
    logic [7:0] exp_ctl;
    bit in_as, in_ds, in_hold;
    w         = stuck ? TIMEOUT : waits;
    t_as      = 1 + T_ADDR;
    t_ds      = t_as + T_AS2DS;
    t_ds_end  = t_ds + T_DS;
    t_hold    = t_ds_end + w;
    t_end     = t_hold + T_DOE;
    exp_rdata = (rd && !stuck) ? rdata : '0;

    chk($sformatf("%s_push_ready", tag), cmd_ready, 1);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    @(posedge z_sample_clk);
    #1;
    cmd_valid = 1'b0; cmd_read = ~rd; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = ~be;
    for (int e = 0; e <= t_end + 1; e++) begin
      @(negedge z_sample_clk);
      in_as   = (e >= t_as) && (e < t_end);
      in_ds   = (e >= t_ds) && (e < t_hold);
      in_hold = (e >= t_hold) && (e < t_end);
      exp_ctl = {!in_as, !(in_ds && be[1]), !(in_ds && be[0]),
                 ((e >= 1) && (e <= t_end)) ? rd : 1'b1,
                 in_hold, in_as && !rd, e == t_end, 1'b1};
      chk($sformatf("%s_ctl@%0d", tag, e), ctl_obs(), exp_ctl);
      chk($sformatf("%s_zA@%0d", tag, e), zA, (e >= 1) ? addr : last_addr);
      if (in_as && !rd) chk($sformatf("%s_zD_out@%0d", tag, e), zD_out, wdata);
      if (e == t_end)
        chk($sformatf("%s_rsp", tag), {rsp_read, rsp_err, rsp_rdata}, {rd, stuck, exp_rdata});
      // Slave behaviour for the coming edge e+1.
      zXRDY = !(((e + 1) >= t_ds_end) && (stuck || ((e + 1) < t_hold)));
      zD_in = in_hold ? rdata : ~rdata;
    end
    last_addr = addr;
    zXRDY = 1'b1;
  endtask

  // ---------------- back-to-back / FIFO full ----------------
  task automatic run_b2b();
    logic              c_rd[6];
    logic [ADDR_W-1:0] c_addr[6];
    logic [DATA_W-1:0] c_wd[6];
    logic [1:0]        c_be[6];
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W:0]   exp_e;
    int  n_push, n_pop, occ, k;
    bit  exp_ready, pushed, popped, exp_rv;
    rd_val = $urandom;
    zD_in  = rd_val;
    zXRDY  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_rd[i] = 1'($urandom_range(0, 1)); c_addr[i] = $urandom;
      c_wd[i] = $urandom; c_be[i] = 2'($urandom_range(0, 3));
      exp_q.push_back({c_rd[i], c_rd[i] ? rd_val : {DATA_W{1'b0}}});
    end
    n_push = 0; n_pop = 0; occ = 0;
    cmd_valid = 1'b1; cmd_read = c_rd[0]; cmd_addr = c_addr[0];
    cmd_wdata = c_wd[0]; cmd_be = c_be[0];
    for (int e = 0; e <= 6 * CYC + 4; e++) begin
      // Negedge before edge e.
      exp_ready = (occ < FIFO_DEPTH);
      chk($sformatf("b2b_ready@%0d", e - 1), cmd_ready, exp_ready);
      @(posedge z_sample_clk);
      pushed = cmd_valid && exp_ready;
      popped = (e >= 1) && ((e - 1) % CYC == 0) && (n_pop < n_push);
      occ = occ + (pushed ? 1 : 0) - (popped ? 1 : 0);
      if (pushed) n_push++;
      if (popped) n_pop++;
      #1;
      if (n_push < 6) begin
        cmd_valid = 1'b1; cmd_read = c_rd[n_push]; cmd_addr = c_addr[n_push];
        cmd_wdata = c_wd[n_push]; cmd_be = c_be[n_push];
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge z_sample_clk);
      k = (e - (CYC - 1)) / CYC;
      exp_rv = (e >= CYC - 1) && ((e - (CYC - 1)) % CYC == 0) && (k < 6);
      chk($sformatf("b2b_rsp_valid@%0d", e), rsp_valid, exp_rv);
      if (exp_rv && exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        chk($sformatf("b2b_rsp%0d", k), {rsp_err, rsp_read, rsp_rdata}, {1'b0, exp_e});
      end
    end
    chk("b2b_all_rsp", exp_q.size(), 0);
    chk("b2b_all_pushed", n_push, 6);
    last_addr = c_addr[5];
  endtask

  // ---------------- reset in the middle of DS ----------------
  task automatic run_rst_mid();
    chk("rst_push_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 24'h123456; cmd_wdata = 16'hA5C3; cmd_be = 2'b11;
    @(posedge z_sample_clk);
    #1 cmd_addr = 24'h654321;     // second command, pushed on the pop edge
    @(posedge z_sample_clk);
    #1 cmd_valid = 1'b0;
    repeat (34) @(posedge z_sample_clk);
    @(negedge z_sample_clk);      // window after edge 35: inside DS
    chk("rst_pre_ds", {znAS, znUDS, znLDS, zDOE, zD_oe}, 5'b00001);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async", {znAS, znUDS, znLDS, zDOE, zD_oe}, 5'b11100);
    check_reset_vals("rst_low");
    @(negedge z_sample_clk);
    @(negedge z_sample_clk);
    reset_n = 1'b1;
    last_addr = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge z_sample_clk);
      check_reset_vals($sformatf("rst_after@%0d", i));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_be = 2'b00; zD_in = '0; zXRDY = 1'b1; last_addr = '0;
    repeat (3) @(negedge z_sample_clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge z_sample_clk);
    check_reset_vals("post_reset");

    run_cycle(1'b0, 24'hE80000, 16'hBEEF, 2'b11, 16'h0000, 0, 1'b0, "wr_beef");
    run_cycle(1'b1, 24'hE80002, 16'h0000, 2'b11, 16'h1234, 0, 1'b0, "rd_1234");
    run_cycle(1'b0, 24'hE80004, 16'h5A5A, 2'b10, 16'h0000, 0, 1'b0, "wr_be10");
    run_cycle(1'b0, 24'hE80006, 16'hC3C3, 2'b00, 16'h0000, 0, 1'b0, "wr_be00");
    run_cycle(1'b1, 24'hE80008, 16'h0000, 2'b11, 16'h9876, 5, 1'b0, "rd_wait5");

    for (int i = 0; i < 8; i++)
      run_cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
                2'($urandom_range(0, 3)), DATA_W'($urandom), $urandom_range(0, 6),
                1'b0, $sformatf("rand%0d", i));

`ifdef Z2CG_TIMEOUT_EN
    run_cycle(1'b1, 24'hE8000A, 16'h0000, 2'b11, 16'hFACE, 0, 1'b1, "timeout");
`endif

    run_b2b();
    run_rst_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
